axis_packet_fifo: RTL and testbench
===================================

# axis_packet_fifo

Synchronous AXI4-Stream FIFO of configurable depth, placed directly upstream of `axis_skid_buffer` to absorb bursts before the registered-ready boundary. All sideband fields (TDATA, TSTRB, TKEEP, TLAST, TID, TDEST, TUSER) are stored as one word. An optional packet mode holds output until a complete TLAST-terminated packet is stored (store-and-forward).

## Interface
- `DEPTH`, 16: number of stored words. Must be a power of two, ≥ 2. Any other value is an elaboration `$error`.
- `i_clk`  in  1: the single clock. Interface ACLK is not used.
- `i_rst`  in  1: synchronous, active-high reset. Interface ARESETn is not used.
- `s_axis`  `axis_if.rx`  —: input stream. It must have identical `AXIS_PARAMETERS` to `m_axis`, otherwise elaboration `$error`.
- `m_axis`  `axis_if.tx`  —: output stream.
- `o_count`  out  $clog2(DEPTH)+1: number of words currently stored.
- `o_oversize`  out  1: one-cycle pulse when packet mode force-releases a partial packet.

## Operation
- Word layout: {TUSER, TDEST, TID, TLAST, TKEEP, TSTRB, TDATA}. Width = TDATA_WIDTH + 2·TDATA_BYTES + 1 + TID_WIDTH + TDEST_WIDTH + TUSER_WIDTH.
- Pointers `wr_ptr`, `rd_ptr`, `commit_ptr` are each $clog2(DEPTH)+1 bits (MSB is the wrap bit). They wrap modulo 2·DEPTH.
- `full` = (wr_ptr − rd_ptr == DEPTH). `o_count` = wr_ptr − rd_ptr, computed modulo the pointer width.
- Write: occurs when s_axis.TVALID && s_axis.TREADY. The word is stored at wr_ptr[low bits], then wr_ptr increments.
- Read: occurs when m_axis.TVALID && m_axis.TREADY. rd_ptr increments.
- First-word-fall-through: m_axis data is the memory word at rd_ptr. It stays stable while TVALID && !TREADY.
- s_axis.TREADY = !full && !i_rst.
- m_axis.TVALID = (rd_ptr != commit_ptr).
- Non-packet mode: commit_ptr tracks wr_ptr every cycle.
- Simultaneous read and write are both accepted in the same cycle, and o_count is unchanged. This applies when not full; when full, TREADY is 0 so no write occurs.
- Empty: there is no bypass. An incoming word is never visible on m_axis in the cycle it is written.

## Timing
- Reset (i_rst high at a clock edge): all pointers become 0 and stored contents are discarded. After that edge: o_count = 0, m_axis.TVALID = 0, o_oversize = 0. s_axis.TREADY = 0 while i_rst is high, and 1 from the first cycle i_rst is low.
- Reset mid-packet discards the partial packet. No TLAST is synthesized.
- Latency:
  - Non-packet mode: a word written at edge N gives m_axis.TVALID = 1 in cycle N+1.
  - Packet mode: m_axis.TVALID rises in the cycle after the TLAST word is written.
- Free slot: a word read at edge N raises s_axis.TREADY in cycle N+1 (pointers are registered; there is no combinational ready path from m_axis.TREADY).
- Throughput: one word per cycle sustained when both sides are ready.

## Configuration
- `AXIS_PACKET_FIFO_PACKET_MODE_EN` defined (packet mode):
  - commit_ptr ← wr_ptr + 1 when the written word has TLAST = 1.
  - Oversize handling: if full && commit_ptr == rd_ptr (a whole FIFO with no complete packet), then commit_ptr ← wr_ptr and o_oversize pulses for 1 cycle. Remaining words of that packet then flow in cut-through until its TLAST, which commits normally.
- Not defined: commit_ptr tracks wr_ptr (plain FIFO), and o_oversize is tied to 0.

## Structure
- Shared package `axis_pkg`: function `axis_word_width(params)` and a constant for pointer-width derivation, so the skid buffer and FIFO agree on word width.
- Sub-module `sync_fifo_ram`: simple dual-port memory with `DEPTH` × width, synchronous write and asynchronous read, no reset on the array.
- Top level contains pointers, commit logic, flags and interface packing.

## Test plan
- Reset, then write 3 words (TDATA 0x11, 0x22, 0x33) with m_axis.TREADY = 0 → o_count = 3 and TVALID = 1 from the cycle after the first write. Then TREADY = 1 → words emerge in order over 3 cycles, and o_count returns to 0.
- Fill DEPTH = 16 words with TREADY = 0 → s_axis.TREADY = 0 once o_count = 16. Pop one → TREADY = 1 in the next cycle. Push one → full again. Data order intact across pointer wrap (run 40 words).
- Continuous stream, both sides ready for 100 cycles → 1 word/cycle, o_count constant, TID/TDEST/TUSER/TKEEP preserved bit-exact.
- Packet mode: 5-word packet with TLAST on word 5 → m_axis.TVALID stays 0 through word 4 and rises the cycle after word 5 is written.
- Packet mode: 20-word packet, DEPTH = 16, TREADY = 1 → o_oversize pulses once when full. All 20 words are output in order with TLAST on word 20.
- Assert i_rst for 1 cycle mid-packet with 7 words stored → o_count = 0 and TVALID = 0 next cycle. A subsequent packet passes cleanly with no stale words.

Source files
------------

// File: rtl/axis_pkg.sv
// axis_pkg: shared AXI4-Stream parameter record plus word-width and pointer-width helpers
package axis_pkg;
  typedef struct packed {
    int unsigned tdata_width;
    int unsigned tid_width;
    int unsigned tdest_width;
    int unsigned tuser_width;
  } axis_params_t;
  // one extra pointer bit tells full from empty when the low bits match
  localparam int unsigned AXIS_PTR_WRAP_BITS = 1;
  function automatic int unsigned axis_word_width(axis_params_t p);
    return p.tdata_width + 2 * (p.tdata_width / 8) + 1 + p.tid_width + p.tdest_width + p.tuser_width;
  endfunction
  function automatic int unsigned axis_ptr_width(int unsigned depth);
    return $clog2(depth) + AXIS_PTR_WRAP_BITS;
  endfunction
endpackage

// File: rtl/axis_if.sv
// axis_if: AXI4-Stream bundle; ACLK/ARESETn are left out, users clock and reset through their own ports
interface axis_if #(
  parameter int TDATA_WIDTH = 32,
  parameter int TID_WIDTH   = 1,
  parameter int TDEST_WIDTH = 1,
  parameter int TUSER_WIDTH = 1
);
  localparam int TDATA_BYTES = TDATA_WIDTH / 8;
  logic [TDATA_WIDTH-1:0] tdata;
  logic [TDATA_BYTES-1:0] tstrb;
  logic [TDATA_BYTES-1:0] tkeep;
  logic                   tlast;
  logic [TID_WIDTH-1:0]   tid;
  logic [TDEST_WIDTH-1:0] tdest;
  logic [TUSER_WIDTH-1:0] tuser;
  logic                   tvalid;
  logic                   tready;
  modport rx (input tdata, tstrb, tkeep, tlast, tid, tdest, tuser, tvalid, output tready);
  modport tx (output tdata, tstrb, tkeep, tlast, tid, tdest, tuser, tvalid, input tready);
endinterface

// File: rtl/axis_packet_fifo_ram.sv
// sync_fifo_ram: DEPTH x WIDTH dual-port storage, synchronous write, asynchronous read, array never reset
module sync_fifo_ram #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                     i_clk,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_waddr,
  input  logic [WIDTH-1:0]         i_wdata,
  input  logic [$clog2(DEPTH)-1:0] i_raddr,
  output logic [WIDTH-1:0]         o_rdata
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  // write port; contents are meaningless until the pointers say otherwise
  always_ff @(posedge i_clk) begin
    if (i_we) mem_q[i_waddr] <= i_wdata;
  end
  assign o_rdata = mem_q[i_raddr];
endmodule

// File: rtl/axis_packet_fifo.sv
// axis_packet_fifo: first-word-fall-through AXI4-Stream FIFO; define AXIS_PACKET_FIFO_PACKET_MODE_EN for store-and-forward
module axis_packet_fifo
  import axis_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  axis_if.rx                     s_axis,
  axis_if.tx                     m_axis,
  output logic [$clog2(DEPTH):0] o_count,
  output logic                   o_oversize
);
  localparam int unsigned DW = s_axis.TDATA_WIDTH;
  localparam int unsigned IW = s_axis.TID_WIDTH;
  localparam int unsigned SW = s_axis.TDEST_WIDTH;
  localparam int unsigned UW = s_axis.TUSER_WIDTH;
  localparam axis_params_t P = '{tdata_width: DW, tid_width: IW, tdest_width: SW, tuser_width: UW};
  localparam int unsigned W  = axis_word_width(P);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = axis_ptr_width(DEPTH);
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("axis_packet_fifo: DEPTH=%0d is not a power of two >= 2", DEPTH);
  end
  if (m_axis.TDATA_WIDTH != DW || m_axis.TID_WIDTH != IW || m_axis.TDEST_WIDTH != SW || m_axis.TUSER_WIDTH != UW) begin : g_bad_params
    $error("axis_packet_fifo: s_axis and m_axis parameters differ");
  end
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d, cm_q, cm_d;
  logic [W-1:0]  wdata, rdata;
  logic          full, wr_en, rd_en;
  assign o_count       = wr_q - rd_q;
  assign full          = o_count == PW'(DEPTH);
  assign s_axis.tready = !full && !i_rst;
  assign m_axis.tvalid = rd_q != cm_q;
  assign wr_en         = s_axis.tvalid && s_axis.tready;
  assign rd_en         = m_axis.tvalid && m_axis.tready;
  assign wdata = {s_axis.tuser, s_axis.tdest, s_axis.tid, s_axis.tlast, s_axis.tkeep, s_axis.tstrb, s_axis.tdata};
  assign {m_axis.tuser, m_axis.tdest, m_axis.tid, m_axis.tlast, m_axis.tkeep, m_axis.tstrb, m_axis.tdata} = rdata;
  // advance each pointer on its own handshake
  always_comb begin
    wr_d = wr_en ? wr_q + 1'b1 : wr_q;
    rd_d = rd_en ? rd_q + 1'b1 : rd_q;
  end
`ifdef AXIS_PACKET_FIFO_PACKET_MODE_EN
  logic cut_q, cut_d, force_rel;
  assign force_rel  = full && cm_q == rd_q;
  assign o_oversize = force_rel;
  // commit on TLAST; a packet that fills the FIFO is released and cut through until its TLAST
  always_comb begin
    cm_d  = force_rel ? wr_q : (cut_q || (wr_en && s_axis.tlast)) ? wr_d : cm_q;
    cut_d = force_rel ? 1'b1 : (wr_en && s_axis.tlast) ? 1'b0 : cut_q;
  end
  // cut-through flag is dropped with the partial packet on reset
  always_ff @(posedge i_clk) begin
    cut_q <= i_rst ? 1'b0 : cut_d;
  end
`else
  assign o_oversize = 1'b0;
  // plain FIFO: every written word is committed at once
  always_comb begin
    cm_d = wr_d;
  end
`endif
  // pointer state; reset empties the FIFO by collapsing all pointers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_q <= '0;
      rd_q <= '0;
      cm_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      cm_q <= cm_d;
    end
  end
  sync_fifo_ram #(.DEPTH(DEPTH), .WIDTH(W)) u_ram (
    .i_clk  (i_clk),
    .i_we   (wr_en),
    .i_waddr(wr_q[AW-1:0]),
    .i_wdata(wdata),
    .i_raddr(rd_q[AW-1:0]),
    .o_rdata(rdata)
  );
endmodule

// File: tb/tb_axis_packet_fifo.sv
// tb_axis_packet_fifo: randomized scoreboard bench against a queue-based model of the FIFO
module tb_axis_packet_fifo;
  localparam int DEPTH = 16;
  localparam int W     = 50;
  localparam int LAST  = 40;
`ifdef AXIS_PACKET_FIFO_PACKET_MODE_EN
  localparam bit PKT = 1'b1;
`else
  localparam bit PKT = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  axis_if #(.TDATA_WIDTH(32), .TID_WIDTH(4), .TDEST_WIDTH(3), .TUSER_WIDTH(2)) s_if ();
  axis_if #(.TDATA_WIDTH(32), .TID_WIDTH(4), .TDEST_WIDTH(3), .TUSER_WIDTH(2)) m_if ();
  logic [4:0] count;
  logic       oversize;
  axis_packet_fifo #(.DEPTH(DEPTH)) dut (
    .i_clk(clk), .i_rst(rst), .s_axis(s_if), .m_axis(m_if), .o_count(count), .o_oversize(oversize)
  );
  logic [W-1:0] sb[$];
  int  vis = 0;
  bit  cut = 1'b0;
  bit  mon_en = 1'b0;
  int  checks = 0, passed = 0, ov_seen = 0, cyc = 0, rdy_mode = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [W-1:0] word(input bit last);
    logic [63:0] r;
    r = {$urandom, $urandom};
    r[LAST] = last;
    return r[W-1:0];
  endfunction

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    #2 m_if.tready = rst ? 1'b0 : (rdy_mode == 2) ? 1'($urandom_range(0, 1)) : (rdy_mode == 1);
  end

  always @(negedge clk) begin : mon
    logic [W-1:0] got;
    bit exp_ov;
    if (mon_en) begin
      exp_ov = PKT && sb.size() == DEPTH && vis == 0;
      check("count", count, sb.size());
      check("s_tready", s_if.tready, !rst && sb.size() < DEPTH);
      check("m_tvalid", m_if.tvalid, vis > 0);
      check("oversize", oversize, exp_ov);
      if (oversize) ov_seen++;
      if (exp_ov) begin
        vis = sb.size();
        cut = 1'b1;
      end
      if (m_if.tvalid && m_if.tready && !rst) begin
        got = {m_if.tuser, m_if.tdest, m_if.tid, m_if.tlast, m_if.tkeep, m_if.tstrb, m_if.tdata};
        check("sb_nonempty", sb.size() != 0, 1);
        if (sb.size() != 0) begin
          check("data", got, sb.pop_front());
          vis--;
        end
      end
    end
  end

  task automatic push(input logic [W-1:0] w);
    int n = 0;
    {s_if.tuser, s_if.tdest, s_if.tid, s_if.tlast, s_if.tkeep, s_if.tstrb, s_if.tdata} = w;
    s_if.tvalid = 1'b1;
    @(negedge clk);
    while (!s_if.tready && n < 300) begin
      n++;
      @(negedge clk);
    end
    if (!s_if.tready) begin
      check("push_wait_tready", s_if.tready, 1);
      s_if.tvalid = 1'b0;
      return;
    end
    @(posedge clk);
    sb.push_back(w);
    if (cut || !PKT) vis++;
    if (PKT && w[LAST]) begin
      vis = sb.size();
      cut = 1'b0;
    end
    #1 s_if.tvalid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    rdy_mode = 1;
    while (sb.size() != 0 && n < 500) begin
      @(posedge clk);
      n++;
    end
    check("drain_empty", sb.size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    logic [W-1:0] w;
    int c0, ov0;
    {s_if.tuser, s_if.tdest, s_if.tid, s_if.tlast, s_if.tkeep, s_if.tstrb, s_if.tdata} = '0;
    s_if.tvalid = 1'b0;
    @(posedge clk);
    #1 mon_en = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    // three words held back, then released in order
    for (int i = 0; i < 3; i++) begin
      w = word(i == 2);
      w[31:0] = 32'h11 * (i + 1);
      push(w);
    end
    repeat (2) @(posedge clk);
    #1 check("count_after_3", count, 3);
    drain();
    // fill to full, pop one, refill
    rdy_mode = 0;
    for (int i = 0; i < DEPTH; i++) push(word(i == DEPTH - 1));
    repeat (3) @(posedge clk);
    #1 check("full_count", count, DEPTH);
    rdy_mode = 1;
    @(posedge clk);
    #1 rdy_mode = 0;
    push(word(1'b1));
    @(posedge clk);
    #1 check("refull_count", count, DEPTH);
    // 40 words across the pointer wrap with random backpressure
    rdy_mode = 2;
    for (int i = 0; i < 40; i++) push(word(i == 39 || $urandom_range(0, 3) == 0));
    drain();
    // continuous stream
    rdy_mode = 1;
    c0 = cyc;
    for (int i = 0; i < 100; i++) push(word(i == 99 || $urandom_range(0, 7) == 0));
`ifndef AXIS_PACKET_FIFO_PACKET_MODE_EN
    check("stream_cycles", cyc - c0, 100);
`endif
    drain();
`ifdef AXIS_PACKET_FIFO_PACKET_MODE_EN
    for (int i = 0; i < 5; i++) push(word(i == 4));
    drain();
    ov0 = ov_seen;
    for (int i = 0; i < 20; i++) push(word(i == 19));
    drain();
    check("oversize_pulses", ov_seen - ov0, 1);
`endif
    // reset with a partial packet stored
    rdy_mode = 0;
    for (int i = 0; i < 7; i++) push(word(1'b0));
    rst = 1'b1;
    @(posedge clk);
    sb.delete();
    vis = 0;
    cut = 1'b0;
    #1 rst = 1'b0;
    check("count_after_rst", count, 0);
    check("tvalid_after_rst", m_if.tvalid, 0);
    for (int i = 0; i < 4; i++) push(word(i == 3));
    drain();
`ifndef AXIS_PACKET_FIFO_PACKET_MODE_EN
    check("no_oversize", ov_seen, 0);
`endif
    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
